ram_port_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one single-port, byte-enabled 32-bit data RAM (18-bit byte address, one-cycle synchronous read) between N requesters, e.g. several cores' load/store units. It issues at most one access per cycle, routes the registered read data back to the requester that issued it, and optionally supports a lock for atomic read-modify-write sequences. It sits between the requesters' memory stages and the RAM instance.

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/rr_picker.sv | 48 ++++
 rtl/ram_port_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared definitions for the RAM port arbiter: RAM word geometry, the lock
// state encoding, and a helper that sizes requester-index fields.
package ram_arb_pkg;

    localparam int RAM_DATA_W = 32;
    localparam int RAM_BE_W   = 4;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // Width of an index that selects one of n items (never less than one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker
// Combinational round-robin picker: scans the request vector starting at
// position ptr and wrapping around, and returns the first requester found.
// Ports:
//   req   in   N       request vector
//   ptr   in   IDX_W   position where the search starts
//   grant out  N       one-hot grant (all zero when nothing is requested)
//   idx   out  IDX_W   index of the granted requester (0 when none)
//   found out  1       any requester granted
module rr_picker
    import ram_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;

    // Walk the requesters in priority order ptr, ptr+1, ... (mod N); first hit wins.
    always_comb begin
        grant  = '0;
        idx    = '0;
        found  = 1'b0;
        sum_s  = '0;
        cand_s = '0;
        for (int off = 0; off < N; off++) begin
            // One extra bit keeps the wrap correct when N is not a power of two.
            sum_s  = {1'b0, ptr} + (IDX_W+1)'(off);
            cand_s = (sum_s >= (IDX_W+1)'(N)) ? IDX_W'(sum_s - (IDX_W+1)'(N))
                                              : IDX_W'(sum_s);
            if (!found && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                idx           = cand_s;
                found         = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port, byte-enabled 32-bit RAM (one-cycle synchronous read)
// between N requesters. One access per cycle, round-robin fairness, read data
// returned one cycle after the grant to the requester that issued it.
// Optional lock for atomic read-modify-write sequences, enabled by defining
// the macro RAM_ARB_LOCK_EN (lock FSM, idle timeout and lock_abort present).
// Ports:
//   clock, reset                     clock (rising edge), async active-high reset
//   req_valid/write/lock [N]         per-requester request, direction, lock
//   req_address [N*ADDR_W]           byte address, requester i at slice i
//   req_data [N*32], req_byte_en [N*4]  write data and byte enables
//   req_ready [N]                    one-hot grant, combinational
//   rsp_valid [N], rsp_data [32]     read response, one cycle after grant
//   lock_abort                       one-cycle pulse when a lock times out
//   ram_*                            RAM command out, ram_data_out in
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N            = 4,
    parameter int ADDR_W       = 18,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N-1:0]             req_valid,
    input  logic [N-1:0]             req_write,
    input  logic [N*ADDR_W-1:0]      req_address,
    input  logic [N*RAM_DATA_W-1:0]  req_data,
    input  logic [N*RAM_BE_W-1:0]    req_byte_en,
    input  logic [N-1:0]             req_lock,
    output logic [N-1:0]             req_ready,
    output logic [N-1:0]             rsp_valid,
    output logic [RAM_DATA_W-1:0]    rsp_data,
    output logic                     lock_abort,
    output logic [ADDR_W-1:0]        ram_address,
    output logic [RAM_DATA_W-1:0]    ram_data_in,
    output logic [RAM_BE_W-1:0]      ram_byte_enablers,
    output logic                     ram_write_enable,
    input  logic [RAM_DATA_W-1:0]    ram_data_out
);

    localparam int IDX_W = idx_width(N);

    logic [N-1:0]     req_eff_s;
    logic [N-1:0]     allowed_mask_s;
    logic [N-1:0]     grant_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic             grant_any_s;
    logic             advance_s;

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             pend_valid_q, pend_valid_d;
    logic [IDX_W-1:0] pend_id_q, pend_id_d;

    // Nothing is granted while reset is held, so every output reads zero then.
    assign req_eff_s = req_valid & allowed_mask_s & {N{~reset}};

    rr_picker #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req_eff_s),
        .ptr   (rr_ptr_q),
        .grant (grant_s),
        .idx   (grant_idx_s),
        .found (grant_any_s)
    );

    assign req_ready = grant_s;

    // Steer the granted requester onto the RAM command; idle command is all zero.
    always_comb begin
        ram_address       = '0;
        ram_data_in       = '0;
        ram_byte_enablers = '0;
        ram_write_enable  = 1'b0;
        if (grant_any_s) begin
            ram_address       = req_address[grant_idx_s*ADDR_W +: ADDR_W];
            ram_data_in       = req_data[grant_idx_s*RAM_DATA_W +: RAM_DATA_W];
            ram_write_enable  = req_write[grant_idx_s];
            ram_byte_enablers = req_write[grant_idx_s]
                              ? req_byte_en[grant_idx_s*RAM_BE_W +: RAM_BE_W]
                              : {RAM_BE_W{1'b0}};
        end else begin
            ram_write_enable = 1'b0;
        end
    end

    // Next pointer and pending-read bookkeeping.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        pend_valid_d = 1'b0;
        pend_id_d    = pend_id_q;
        if (grant_any_s && advance_s) begin
            rr_ptr_d = (grant_idx_s == IDX_W'(N-1)) ? {IDX_W{1'b0}}
                                                    : grant_idx_s + IDX_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        if (grant_any_s && !req_write[grant_idx_s]) begin
            pend_valid_d = 1'b1;
            pend_id_d    = grant_idx_s;
        end else begin
            pend_valid_d = 1'b0;
        end
    end

    // Round-robin pointer and pending-read registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            pend_valid_q <= 1'b0;
            pend_id_q    <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
        end
    end

    // The RAM already registers its read data, so the response is that data
    // qualified by the pending flag captured at the grant.
    assign rsp_valid = pend_valid_q ? (N'(1'b1) << pend_id_q) : {N{1'b0}};
    assign rsp_data  = pend_valid_q ? ram_data_out : {RAM_DATA_W{1'b0}};

`ifdef RAM_ARB_LOCK_EN
    localparam int CNT_W = idx_width(LOCK_TIMEOUT);

    lock_state_t      state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             lock_abort_q, lock_abort_d;

    // Lock state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= UNLOCKED;
            owner_q      <= '0;
            idle_cnt_q   <= '0;
            lock_abort_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            idle_cnt_q   <= idle_cnt_d;
            lock_abort_q <= lock_abort_d;
        end
    end

    // Lock next-state: take on a locked grant, drop on an unlocked owner
    // access, or force release after LOCK_TIMEOUT idle cycles.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        idle_cnt_d   = idle_cnt_q;
        lock_abort_d = 1'b0;
        case (state_q)
            UNLOCKED: begin
                if (grant_any_s && req_lock[grant_idx_s]) begin
                    state_d    = LOCKED;
                    owner_d    = grant_idx_s;
                    idle_cnt_d = '0;
                end else begin
                    state_d = UNLOCKED;
                end
            end
            LOCKED: begin
                // Only the owner can be granted here, so any grant is the owner's.
                if (grant_any_s) begin
                    idle_cnt_d = '0;
                    state_d    = req_lock[owner_q] ? LOCKED : UNLOCKED;
                end else if (idle_cnt_q == CNT_W'(LOCK_TIMEOUT-1)) begin
                    state_d      = UNLOCKED;
                    idle_cnt_d   = '0;
                    lock_abort_d = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = UNLOCKED;
                idle_cnt_d = '0;
            end
        endcase
    end

    // Lock outputs: restrict grants to the owner and freeze the pointer while locked.
    always_comb begin
        allowed_mask_s = {N{1'b1}};
        advance_s      = 1'b1;
        if (state_q == LOCKED) begin
            allowed_mask_s = N'(1'b1) << owner_q;
            advance_s      = 1'b0;
        end else begin
            advance_s = 1'b1;
        end
    end

    assign lock_abort = lock_abort_q;
`else
    logic        unused_lock_s;
    logic [31:0] unused_timeout_s;

    assign unused_lock_s    = ^req_lock;
    assign unused_timeout_s = LOCK_TIMEOUT;
    assign allowed_mask_s   = {N{1'b1}};
    assign advance_s        = 1'b1;
    assign lock_abort       = 1'b0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Directed-vector bench for ram_port_arbiter (N=4). A small RAM model returns
// 0xDEADBEEF at address 0x10 and a fixed address-derived pattern elsewhere.
// Lock tests are compiled in when RAM_ARB_LOCK_EN is defined; otherwise the
// bench checks that req_lock is ignored.
module tb_ram_port_arbiter;

    localparam int N      = 4;
    localparam int ADDR_W = 18;

    logic              clock;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_write;
    logic [N*ADDR_W-1:0] req_address;
    logic [N*32-1:0]   req_data;
    logic [N*4-1:0]    req_byte_en;
    logic [N-1:0]      req_lock;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_data;
    logic              lock_abort;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_data_in;
    logic [3:0]        ram_byte_enablers;
    logic              ram_write_enable;
    logic [31:0]       ram_data_out;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(
        .N            (N),
        .ADDR_W       (ADDR_W),
        .LOCK_TIMEOUT (16)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_write         (req_write),
        .req_address       (req_address),
        .req_data          (req_data),
        .req_byte_en       (req_byte_en),
        .req_lock          (req_lock),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .lock_abort        (lock_abort),
        .ram_address       (ram_address),
        .ram_data_in       (ram_data_in),
        .ram_byte_enablers (ram_byte_enablers),
        .ram_write_enable  (ram_write_enable),
        .ram_data_out      (ram_data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Read pattern the RAM model returns for any address other than 0x10.
    function automatic logic [31:0] ram_pattern(input logic [ADDR_W-1:0] a);
        return {14'h0000, a} ^ 32'hA5A5_0000;
    endfunction

    // RAM model: one-cycle synchronous read.
    always @(posedge clock) begin
        ram_data_out <= (ram_address == 18'h00010) ? 32'hDEAD_BEEF : ram_pattern(ram_address);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [31:0] d, input logic [3:0] be, input logic lk);
        req_write[i]              = wr;
        req_address[i*ADDR_W +: ADDR_W] = a;
        req_data[i*32 +: 32]      = d;
        req_byte_en[i*4 +: 4]     = be;
        req_lock[i]               = lk;
    endtask

    task automatic clear_reqs();
        req_valid   = '0;
        req_write   = '0;
        req_address = '0;
        req_data    = '0;
        req_byte_en = '0;
        req_lock    = '0;
    endtask

    initial begin
        reset = 1'b1;
        clear_reqs();
        req_valid = 4'b1111;
        repeat (2) @(posedge clock);

        // Reset: all outputs zero even with every requester valid.
        @(negedge clock); #2;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_we", 32'(ram_write_enable), 32'h0);
        check("rst_addr", 32'(ram_address), 32'h0);
        check("rst_abort", 32'(lock_abort), 32'h0);

        // Single read from requester 2 at 0x10.
        @(negedge clock);
        reset = 1'b0;
        clear_reqs();
        set_req(2, 1'b0, 18'h00010, 32'h0, 4'b1111, 1'b0);
        req_valid = 4'b0100;
        #2;
        check("rd_ready", 32'(req_ready), 32'h4);
        check("rd_addr", 32'(ram_address), 32'h10);
        check("rd_we", 32'(ram_write_enable), 32'h0);
        check("rd_be", 32'(ram_byte_enablers), 32'h0);
        @(negedge clock);
        clear_reqs();
        #2;
        check("rd_rsp_valid", 32'(rsp_valid), 32'h4);
        check("rd_rsp_data", rsp_data, 32'hDEAD_BEEF);
        check("idle_ready", 32'(req_ready), 32'h0);
        check("idle_addr", 32'(ram_address), 32'h0);
        check("idle_data_in", ram_data_in, 32'h0);

        // Write from requester 1: byte enable 0001 at unaligned address 0x3.
        @(negedge clock);
        set_req(1, 1'b1, 18'h00003, 32'h0000_00AB, 4'b0001, 1'b0);
        req_valid = 4'b0010;
        #2;
        check("wr_ready", 32'(req_ready), 32'h2);
        check("wr_we", 32'(ram_write_enable), 32'h1);
        check("wr_be", 32'(ram_byte_enablers), 32'h1);
        check("wr_addr", 32'(ram_address), 32'h3);
        check("wr_data_in", ram_data_in, 32'h0000_00AB);
        @(negedge clock);
        clear_reqs();
        #2;
        check("wr_no_rsp", 32'(rsp_valid), 32'h0);

        // Reset the cycle after a read grant: the pending response is dropped.
        @(negedge clock);
        set_req(1, 1'b0, 18'h00020, 32'h0, 4'b0000, 1'b0);
        req_valid = 4'b0010;
        #2;
        check("rr_rd_ready", 32'(req_ready), 32'h2);
        @(negedge clock);
        reset = 1'b1;
        clear_reqs();
        #2;
        check("rst_mid_rsp", 32'(rsp_valid), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        #2;
        check("rst_after_rsp", 32'(rsp_valid), 32'h0);

        // All four valid: grants 0,1,2,3,0,1,2,3 from a reset pointer.
        @(negedge clock);
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 18'(18'h00100 + 4*i), 32'h0, 4'b0000, 1'b0);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clock);
            #2;
            check($sformatf("rr_grant_%0d", k), 32'(req_ready), 32'h1 << (k % 4));
            if (k > 0) begin
                check($sformatf("rr_rsp_%0d", k), 32'(rsp_valid), 32'h1 << ((k-1) % 4));
                check($sformatf("rr_data_%0d", k), rsp_data,
                      ram_pattern(18'(18'h00100 + 4*((k-1) % 4))));
            end
        end

        // Sparse requests 1 and 3 from pointer 0: 1, 3, then wrap back to 1.
        @(negedge clock);
        req_valid = 4'b1010;
        #2;
        check("sp_grant_0", 32'(req_ready), 32'h2);
        @(negedge clock); #2;
        check("sp_grant_1", 32'(req_ready), 32'h8);
        @(negedge clock); #2;
        check("sp_grant_2", 32'(req_ready), 32'h2);

        // Requester 3 alone moves the pointer to 0 before the lock sequence.
        @(negedge clock);
        clear_reqs();
        set_req(3, 1'b0, 18'h00030, 32'h0, 4'b0000, 1'b0);
        req_valid = 4'b1000;
        #2;
        check("pre_lock_grant", 32'(req_ready), 32'h8);
        @(negedge clock);
        set_req(0, 1'b0, 18'h00040, 32'h0, 4'b0000, 1'b1);
        req_valid = 4'b1001;
        #2;
        check("lock_rd_grant", 32'(req_ready), 32'h1);
        @(negedge clock);
        req_valid = 4'b1000;
        #2;
        check("lock_rd_rsp", 32'(rsp_valid), 32'h1);
`ifdef RAM_ARB_LOCK_EN
        check("lock_stall_0", 32'(req_ready), 32'h0);
        @(negedge clock); #2;
        check("lock_stall_1", 32'(req_ready), 32'h0);
        @(negedge clock);
        set_req(0, 1'b1, 18'h00040, 32'h0000_1234, 4'b1111, 1'b0);
        req_valid = 4'b1001;
        #2;
        check("unlock_wr_grant", 32'(req_ready), 32'h1);
        check("unlock_wr_we", 32'(ram_write_enable), 32'h1);
        @(negedge clock);
        req_valid = 4'b1000;
        #2;
        check("post_unlock_grant", 32'(req_ready), 32'h8);

        // Timeout: owner idle for 16 cycles, then abort pulse and requester 3 runs.
        @(negedge clock);
        clear_reqs();
        set_req(0, 1'b0, 18'h00050, 32'h0, 4'b0000, 1'b1);
        set_req(3, 1'b0, 18'h00060, 32'h0, 4'b0000, 1'b0);
        req_valid = 4'b0001;
        #2;
        check("to_lock_grant", 32'(req_ready), 32'h1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            req_valid = 4'b1000;
            #2;
            check($sformatf("to_stall_%0d", k), 32'(req_ready), 32'h0);
            check($sformatf("to_noabort_%0d", k), 32'(lock_abort), 32'h0);
        end
        @(negedge clock); #2;
        check("to_abort", 32'(lock_abort), 32'h1);
        check("to_grant3", 32'(req_ready), 32'h8);
        @(negedge clock);
        clear_reqs();
        #2;
        check("to_abort_once", 32'(lock_abort), 32'h0);
`else
        check("nolock_grant3", 32'(req_ready), 32'h8);
        check("nolock_abort_0", 32'(lock_abort), 32'h0);
        @(negedge clock);
        clear_reqs();
        #2;
        check("nolock_abort_1", 32'(lock_abort), 32'h0);
`endif

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
